// File: rtl/wrf_seq_checker.sv
// Receive-side WR fabric frame checker: verifies the destination MAC, EtherType, sequence ID
// and the incrementing payload pattern, and keeps saturating good/bad frame counters.
module wrf_seq_checker #(
    parameter int unsigned g_stall_every = 0
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic        snk_cyc_i,
    input  logic        snk_stb_i,
    input  logic        snk_we_i,
    input  logic [1:0]  snk_adr_i,
    input  logic [1:0]  snk_sel_i,
    input  logic [15:0] snk_dat_i,
    output logic        snk_stall_o,
    output logic        snk_ack_o,
    output logic        snk_err_o,
    input  logic        cfg_en_i,
    input  logic        cfg_clr_i,
    input  logic [47:0] cfg_dmac_i,
    input  logic [15:0] cfg_ethertype_i,
    output logic [31:0] frames_ok_o,
    output logic [31:0] frames_bad_o,
    output logic [2:0]  last_err_o,
    output logic        frame_done_o,
    output logic        frame_ok_o
);
    localparam int unsigned SCNT_W = (g_stall_every > 1) ? $clog2(g_stall_every) : 1;
    localparam int unsigned CNT_W  = 32;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_DMAC    = 3'd1;
    localparam logic [2:0] E_ETYPE   = 3'd2;
    localparam logic [2:0] E_SEQ     = 3'd3;
    localparam logic [2:0] E_PAYLOAD = 3'd4;
    localparam logic [2:0] E_RUNT    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_SEQ     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_DROP    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               cyc_q;
    logic [2:0]         wcnt_q, wcnt_d, wcnt_eff;
    logic [7:0]         k_q, k_d;
    logic [15:0]        exp_seq_q, exp_seq_d;
    logic               sync_q, sync_d;
    logic [2:0]         ferr_q, ferr_d;
    logic [CNT_W-1:0]   cnt_ok_q, cnt_ok_d, cnt_bad_q, cnt_bad_d;
    logic [2:0]         last_err_q, last_err_d;
    logic               done_q, done_d, ok_q, ok_d;
    logic               ack_q, stall_q;
    logic [SCNT_W-1:0]  scnt_q;

    logic               accept, data_w, start, active, frame_end;
    logic [2:0]         hdr_err, seq_err, pay_err, chk_err, vcode;

    logic               unused_we;
    assign unused_we = snk_we_i;

    assign accept    = snk_cyc_i & snk_stb_i & ~stall_q;
    assign data_w    = accept & (snk_adr_i == 2'd0);
    assign start     = snk_cyc_i & ~cyc_q;
    assign active    = (state_q != S_IDLE);
    assign frame_end = cfg_en_i & active & ~snk_cyc_i;
    assign wcnt_eff  = active ? wcnt_q : 3'd0;

    // Per-word checks; the first header word may arrive in the same cycle cyc rises
    always_comb begin
        hdr_err = E_NONE;
        case (wcnt_eff)
            3'd0:    if (snk_dat_i != cfg_dmac_i[47:32]) hdr_err = E_DMAC;
            3'd1:    if (snk_dat_i != cfg_dmac_i[31:16]) hdr_err = E_DMAC;
            3'd2:    if (snk_dat_i != cfg_dmac_i[15:0])  hdr_err = E_DMAC;
            3'd6:    if (snk_dat_i != cfg_ethertype_i)   hdr_err = E_ETYPE;
            default: hdr_err = E_NONE;
        endcase
        seq_err = (sync_q && (snk_dat_i != exp_seq_q)) ? E_SEQ : E_NONE;
        pay_err = E_NONE;
        if (snk_dat_i[15:8] != k_q) pay_err = E_PAYLOAD;
        if ((snk_sel_i != 2'b10) && (snk_dat_i[7:0] != 8'(k_q + 8'd1))) pay_err = E_PAYLOAD;
        vcode = (ferr_q != E_NONE) ? ferr_q :
                ((state_q == S_HDR) || (state_q == S_SEQ)) ? E_RUNT : E_NONE;
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        chk_err = E_NONE;
        if (!cfg_en_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_HDR;
                        if (data_w && (hdr_err != E_NONE)) begin
                            chk_err = hdr_err;
                            state_d = S_DROP;
                        end
                    end
                end
                S_HDR: begin
                    if (!snk_cyc_i) begin
                        state_d = S_IDLE;
                    end else if (data_w) begin
                        if (hdr_err != E_NONE) begin
                            chk_err = hdr_err;
                            state_d = S_DROP;
                        end else if (wcnt_q == 3'd6) begin
                            state_d = S_SEQ;
                        end
                    end
                end
                S_SEQ: begin
                    if (!snk_cyc_i) begin
                        state_d = S_IDLE;
                    end else if (data_w) begin
                        chk_err = seq_err;
                        state_d = (seq_err != E_NONE) ? S_DROP : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!snk_cyc_i) begin
                        state_d = S_IDLE;
                    end else if (data_w && (pay_err != E_NONE)) begin
                        chk_err = pay_err;
                        state_d = S_DROP;
                    end
                end
                S_DROP:  if (!snk_cyc_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and verdict next-state; a coincident clear overrides the verdict update
    always_comb begin
        wcnt_d     = wcnt_q;
        k_d        = k_q;
        exp_seq_d  = exp_seq_q;
        sync_d     = sync_q;
        ferr_d     = ferr_q;
        cnt_ok_d   = cnt_ok_q;
        cnt_bad_d  = cnt_bad_q;
        last_err_d = last_err_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        if (cfg_en_i) begin
            if (!active && start) begin
                ferr_d = chk_err;
                wcnt_d = data_w ? 3'd1 : 3'd0;
            end else if (active && snk_cyc_i) begin
                if (chk_err != E_NONE) ferr_d = chk_err;
                if (data_w) begin
                    case (state_q)
                        S_HDR:     wcnt_d = wcnt_q + 3'd1;
                        S_SEQ: begin
                            exp_seq_d = 16'(snk_dat_i + 16'd1);
                            sync_d    = 1'b1;
                            k_d       = 8'd0;
                        end
                        S_PAYLOAD: k_d = (snk_sel_i == 2'b10) ? 8'(k_q + 8'd1) : 8'(k_q + 8'd2);
                        default:   k_d = k_q;
                    endcase
                end
            end
            if (frame_end) begin
                done_d = 1'b1;
                if (vcode == E_NONE) begin
                    ok_d     = 1'b1;
                    cnt_ok_d = (cnt_ok_q == '1) ? cnt_ok_q : cnt_ok_q + CNT_W'(1);
                end else begin
                    ok_d       = 1'b0;
                    cnt_bad_d  = (cnt_bad_q == '1) ? cnt_bad_q : cnt_bad_q + CNT_W'(1);
                    last_err_d = vcode;
                end
            end
        end
        if (cfg_clr_i) begin
            cnt_ok_d   = '0;
            cnt_bad_d  = '0;
            last_err_d = E_NONE;
            sync_d     = 1'b0;
        end
    end

    // cyc_q resets high so a frame cut by reset is only restarted by its next rising cyc
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cyc_q      <= 1'b1;
            wcnt_q     <= '0;
            k_q        <= '0;
            exp_seq_q  <= '0;
            sync_q     <= 1'b0;
            ferr_q     <= E_NONE;
            cnt_ok_q   <= '0;
            cnt_bad_q  <= '0;
            last_err_q <= E_NONE;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
        end else begin
            cyc_q      <= snk_cyc_i;
            wcnt_q     <= wcnt_d;
            k_q        <= k_d;
            exp_seq_q  <= exp_seq_d;
            sync_q     <= sync_d;
            ferr_q     <= ferr_d;
            cnt_ok_q   <= cnt_ok_d;
            cnt_bad_q  <= cnt_bad_d;
            last_err_q <= last_err_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
        end
    end

    // Ack every accepted word; one stall cycle after each g_stall_every accepted words
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
            scnt_q  <= '0;
        end else begin
            ack_q <= accept;
            if (g_stall_every == 0) begin
                stall_q <= 1'b0;
            end else if (stall_q) begin
                stall_q <= 1'b0;
            end else if (accept) begin
                if (scnt_q == SCNT_W'(g_stall_every - 1)) begin
                    stall_q <= 1'b1;
                    scnt_q  <= '0;
                end else begin
                    scnt_q <= scnt_q + SCNT_W'(1);
                end
            end
        end
    end

    assign snk_ack_o    = ack_q;
    assign snk_stall_o  = stall_q;
    assign snk_err_o    = 1'b0;
    assign frames_ok_o  = cnt_ok_q;
    assign frames_bad_o = cnt_bad_q;
    assign last_err_o   = last_err_q;
    assign frame_done_o = done_q;
    assign frame_ok_o   = ok_q;

endmodule

// File: tb/tb_wrf_seq_checker.sv
// Scoreboard bench for wrf_seq_checker: frames are built in the bench, expected verdicts queued
// when a frame ends and compared against each frame_done_o pulse.
module tb_wrf_seq_checker;
    localparam int unsigned STALL_N = 3;
    localparam logic [47:0] DMAC = 48'h0050_cafe_babe;
    localparam logic [15:0] ETYPE = 16'h88f7;

    logic        clk_sys_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        snk_cyc_i = 1'b0, snk_stb_i = 1'b0, snk_we_i = 1'b1;
    logic [1:0]  snk_adr_i = 2'd0, snk_sel_i = 2'b11;
    logic [15:0] snk_dat_i = 16'h0;
    logic        snk_stall_o, snk_ack_o, snk_err_o;
    logic        cfg_en_i = 1'b1, cfg_clr_i = 1'b0;
    logic [47:0] cfg_dmac_i = DMAC;
    logic [15:0] cfg_ethertype_i = ETYPE;
    logic [31:0] frames_ok_o, frames_bad_o;
    logic [2:0]  last_err_o;
    logic        frame_done_o, frame_ok_o;

    wrf_seq_checker #(.g_stall_every(STALL_N)) dut (
        .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i),
        .snk_cyc_i(snk_cyc_i), .snk_stb_i(snk_stb_i), .snk_we_i(snk_we_i),
        .snk_adr_i(snk_adr_i), .snk_sel_i(snk_sel_i), .snk_dat_i(snk_dat_i),
        .snk_stall_o(snk_stall_o), .snk_ack_o(snk_ack_o), .snk_err_o(snk_err_o),
        .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i), .cfg_dmac_i(cfg_dmac_i),
        .cfg_ethertype_i(cfg_ethertype_i), .frames_ok_o(frames_ok_o),
        .frames_bad_o(frames_bad_o), .last_err_o(last_err_o),
        .frame_done_o(frame_done_o), .frame_ok_o(frame_ok_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    typedef struct {
        logic        ok;
        logic [2:0]  err;
        logic [31:0] n_ok;
        logic [31:0] n_bad;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0, failures = 0;
    int          cyc_cnt = 0, ack_cnt = 0, done_cnt = 0;
    logic [31:0] m_ok = 0, m_bad = 0;
    logic [2:0]  m_last = 0;
    logic [15:0] fw[$];
    logic [1:0]  fs[$];
    logic [1:0]  fa[$];
    bit          rec_stall = 0;
    int          stall_hist[$];

    always @(posedge clk_sys_i) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk_sys_i) begin
        if (snk_ack_o) ack_cnt++;
        if (frame_done_o) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done at cycle %0d", cyc_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                checks += 5;
                if (frame_ok_o !== mon_e.ok) begin
                    failures++; $display("FAIL frame_ok got=%0b exp=%0b", frame_ok_o, mon_e.ok);
                end
                if (frames_ok_o !== mon_e.n_ok) begin
                    failures++; $display("FAIL frames_ok got=%h exp=%h", frames_ok_o, mon_e.n_ok);
                end
                if (frames_bad_o !== mon_e.n_bad) begin
                    failures++; $display("FAIL frames_bad got=%h exp=%h", frames_bad_o, mon_e.n_bad);
                end
                if (last_err_o !== mon_e.err) begin
                    failures++; $display("FAIL last_err got=%0d exp=%0d", last_err_o, mon_e.err);
                end
                if (cyc_cnt != mon_e.done_cyc) begin
                    failures++; $display("FAIL done_latency got=%0d exp=%0d", cyc_cnt, mon_e.done_cyc);
                end
            end
        end
    end

    task automatic push_w(input logic [15:0] d, input logic [1:0] s, input logic [1:0] a);
        fw.push_back(d); fs.push_back(s); fa.push_back(a);
    endtask

    task automatic build(input logic [47:0] dm, input logic [15:0] et, input logic [15:0] seq,
                         input int nbytes);
        logic [7:0] hi;
        fw.delete(); fs.delete(); fa.delete();
        push_w(dm[47:32], 2'b11, 2'd0); push_w(dm[31:16], 2'b11, 2'd0); push_w(dm[15:0], 2'b11, 2'd0);
        push_w(16'h0011, 2'b11, 2'd0); push_w(16'h2233, 2'b11, 2'd0); push_w(16'h4455, 2'b11, 2'd0);
        push_w(et, 2'b11, 2'd0);
        push_w(seq, 2'b11, 2'd0);
        for (int b = 0; b < nbytes; b += 2) begin
            hi = b[7:0];
            if (b + 1 < nbytes) push_w({hi, 8'(b + 1)}, 2'b11, 2'd0);
            else                push_w({hi, 8'h5a}, 2'b10, 2'd0);
        end
    endtask

    task automatic push_expect(input logic [2:0] code);
        exp_t e;
        if (code == 3'd0) begin
            if (m_ok != 32'hFFFF_FFFF) m_ok = m_ok + 1;
        end else begin
            if (m_bad != 32'hFFFF_FFFF) m_bad = m_bad + 1;
            m_last = code;
        end
        e.ok = (code == 3'd0); e.err = m_last; e.n_ok = m_ok; e.n_bad = m_bad;
        e.done_cyc = cyc_cnt + 1;
        exp_q.push_back(e);
    endtask

    // Drive fw[from..to-1] with cyc already high, holding each word while stalled
    task automatic drive_words(input int from, input int to);
        int i = from;
        int guard = 0;
        logic st;
        while (i < to && guard < 2000) begin
            snk_stb_i = 1'b1; snk_dat_i = fw[i]; snk_sel_i = fs[i]; snk_adr_i = fa[i];
            st = snk_stall_o;
            if (rec_stall && st) stall_hist.push_back(cyc_cnt);
            @(negedge clk_sys_i);
            if (!st) i++;
            guard++;
        end
        snk_stb_i = 1'b0;
        if (i < to) begin
            checks++; failures++;
            $display("FAIL drive_timeout sent=%0d required=%0d", i, to);
        end
    endtask

    task automatic cyc_down(input logic [2:0] code, input bit expect_verdict);
        snk_cyc_i = 1'b0;
        if (expect_verdict) push_expect(code);
        @(negedge clk_sys_i);
    endtask

    task automatic send(input logic [2:0] code);
        snk_cyc_i = 1'b1;
        drive_words(0, fw.size());
        cyc_down(code, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys_i);
    endtask

    task automatic wait_verdicts;
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk_sys_i); n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL verdict_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        idle(3);
    endtask

    task automatic test_reset;
        idle(3);
        checks += 3;
        if ({snk_stall_o, snk_ack_o, snk_err_o, frame_done_o, frame_ok_o} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000",
                                 {snk_stall_o, snk_ack_o, snk_err_o, frame_done_o, frame_ok_o});
        end
        if (frames_ok_o !== 32'h0 || frames_bad_o !== 32'h0) begin
            failures++; $display("FAIL reset_counters got=%h/%h exp=0/0", frames_ok_o, frames_bad_o);
        end
        if (last_err_o !== 3'd0) begin
            failures++; $display("FAIL reset_last_err got=%0d exp=0", last_err_o);
        end
        rst_n_i = 1'b1;
        idle(2);
        checks++;
        if (snk_stall_o !== 1'b0 || frame_done_o !== 1'b0) begin
            failures++; $display("FAIL post_reset got=%b%b exp=00", snk_stall_o, frame_done_o);
        end
    endtask

    task automatic test_good_frame;
        int a0;
        a0 = ack_cnt;
        build(DMAC, ETYPE, 16'd5, 48);
        send(3'd0);
        wait_verdicts();
        checks++;
        if (ack_cnt - a0 != 32) begin
            failures++; $display("FAIL good_acks got=%0d exp=32", ack_cnt - a0);
        end
    endtask

    task automatic test_clear;
        cfg_clr_i = 1'b1; @(negedge clk_sys_i); cfg_clr_i = 1'b0; @(negedge clk_sys_i);
        m_ok = 0; m_bad = 0; m_last = 0;
        checks++;
        if (frames_ok_o !== 32'h0 || frames_bad_o !== 32'h0 || last_err_o !== 3'd0) begin
            failures++; $display("FAIL clear got=%h/%h/%0d exp=0/0/0", frames_ok_o, frames_bad_o, last_err_o);
        end
    endtask

    task automatic test_seq;
        build(DMAC, ETYPE, 16'd7, 8);  send(3'd0); idle(1);
        build(DMAC, ETYPE, 16'd8, 8);  send(3'd0); idle(1);
        build(DMAC, ETYPE, 16'd10, 8); send(3'd3); idle(1);
        build(DMAC, ETYPE, 16'd11, 8); send(3'd0);
        wait_verdicts();
    endtask

    task automatic test_field_errors;
        build(DMAC, ETYPE, 16'd12, 8); fw[1] = 16'hcaff; send(3'd1); idle(1);
        build(DMAC, 16'h0800, 16'd12, 8); send(3'd2); idle(1);
        build(DMAC, ETYPE, 16'd12, 32);
        fw[12] = {8'h08, 8'hff};
        fw[18] = {8'hee, 8'h15};
        send(3'd4);
        wait_verdicts();
    endtask

    task automatic test_odd_wrap;
        build(DMAC, ETYPE, 16'd13, 257);
        fw.insert(3, 16'hdead); fs.insert(3, 2'b11); fa.insert(3, 2'd1);
        push_w(16'hbeef, 2'b11, 2'd2);
        send(3'd0);
        wait_verdicts();
    endtask

    task automatic test_runt;
        build(DMAC, ETYPE, 16'd14, 8);
        snk_cyc_i = 1'b1;
        drive_words(0, 4);
        cyc_down(3'd5, 1'b1);
        wait_verdicts();
    endtask

    task automatic test_back_to_back;
        build(DMAC, ETYPE, 16'd14, 20); send(3'd0);
        build(DMAC, ETYPE, 16'd15, 20); send(3'd0);
        build(DMAC, ETYPE, 16'd17, 20); send(3'd3);
        wait_verdicts();
    endtask

    task automatic test_stall;
        stall_hist.delete();
        rec_stall = 1;
        build(DMAC, ETYPE, 16'd18, 48);
        send(3'd0);
        rec_stall = 0;
        wait_verdicts();
        checks++;
        if (stall_hist.size() < 7) begin
            failures++; $display("FAIL stall_count got=%0d exp>=7", stall_hist.size());
        end
        for (int j = 1; j < stall_hist.size(); j++) begin
            checks++;
            if (stall_hist[j] - stall_hist[j-1] != int'(STALL_N) + 1) begin
                failures++; $display("FAIL stall_period got=%0d exp=%0d",
                                     stall_hist[j] - stall_hist[j-1], STALL_N + 1);
            end
        end
    endtask

    task automatic test_disable;
        int a0, d0;
        a0 = ack_cnt; d0 = done_cnt;
        cfg_en_i = 1'b0;
        build(DMAC, ETYPE, 16'd99, 10);
        fw[0] = 16'h1234;
        snk_cyc_i = 1'b1; drive_words(0, fw.size()); cyc_down(3'd0, 1'b0);
        idle(4);
        cfg_en_i = 1'b1;
        checks += 2;
        if (ack_cnt - a0 != fw.size() || done_cnt != d0) begin
            failures++; $display("FAIL disable_acks_done got=%0d/%0d exp=%0d/0",
                                 ack_cnt - a0, done_cnt - d0, fw.size());
        end
        if (frames_ok_o !== m_ok || frames_bad_o !== m_bad) begin
            failures++; $display("FAIL disable_frozen got=%h/%h exp=%h/%h", frames_ok_o, frames_bad_o, m_ok, m_bad);
        end
    endtask

    task automatic test_reset_mid;
        int a0, d0;
        build(DMAC, ETYPE, 16'd19, 40);
        snk_cyc_i = 1'b1;
        drive_words(0, 10);
        rst_n_i = 1'b0;
        @(negedge clk_sys_i);
        checks += 2;
        if (frames_ok_o !== 32'h0 || frames_bad_o !== 32'h0 || last_err_o !== 3'd0) begin
            failures++; $display("FAIL midreset_counters got=%h/%h/%0d exp=0/0/0",
                                 frames_ok_o, frames_bad_o, last_err_o);
        end
        if ({snk_stall_o, snk_ack_o, frame_done_o, frame_ok_o} !== 4'b0) begin
            failures++; $display("FAIL midreset_flags got=%b exp=0000",
                                 {snk_stall_o, snk_ack_o, frame_done_o, frame_ok_o});
        end
        rst_n_i = 1'b1;
        m_ok = 0; m_bad = 0; m_last = 0;
        @(negedge clk_sys_i);
        a0 = ack_cnt; d0 = done_cnt;
        drive_words(10, fw.size());
        cyc_down(3'd0, 1'b0);
        idle(4);
        checks++;
        if (ack_cnt - a0 != fw.size() - 10 || done_cnt != d0) begin
            failures++; $display("FAIL midreset_tail got=%0d/%0d exp=%0d/0",
                                 ack_cnt - a0, done_cnt - d0, fw.size() - 10);
        end
        build(DMAC, ETYPE, 16'd100, 8); send(3'd0);
        wait_verdicts();
    endtask

    task automatic test_saturation;
        force dut.cnt_ok_q = 32'hFFFF_FFFE;
        @(negedge clk_sys_i);
        release dut.cnt_ok_q;
        m_ok = 32'hFFFF_FFFE;
        build(DMAC, ETYPE, 16'd101, 8); send(3'd0); idle(1);
        build(DMAC, ETYPE, 16'd102, 8); send(3'd0);
        wait_verdicts();
        checks++;
        if (frames_ok_o !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL saturation got=%h exp=ffffffff", frames_ok_o);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_sys_i);
        test_reset();
        test_good_frame();
        test_clear();
        test_seq();
        test_field_errors();
        test_odd_wrap();
        test_runt();
        test_back_to_back();
        test_stall();
        test_disable();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
